// File: rtl/fast_arc_scorer.sv
// FAST corner arc scorer: serially scans the 16-pixel ring for a circular arc of MIN_ARC set bits
// and returns the corner flag and score. Optional macro FAST_ARC_EARLY_EXIT_EN ends the scan early.
module fast_arc_scorer #(
  parameter int PIXEL_WIDTH = 8,
  parameter int MIN_ARC     = 9,
  parameter int SCORE_WIDTH = PIXEL_WIDTH + 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ce,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [15:0]                     bright,
  input  logic [15:0]                     dark,
  input  logic [16*(PIXEL_WIDTH+2)-1:0]   diff_b,
  input  logic [16*(PIXEL_WIDTH+2)-1:0]   diff_d,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            corner,
  output logic [SCORE_WIDTH-1:0]          score
);

  localparam int         DW       = PIXEL_WIDTH + 2;
  localparam int         SCAN_LEN = 16 + MIN_ARC - 1;
  localparam logic [4:0] LAST_IDX = 5'(SCAN_LEN - 1);
  localparam logic [4:0] ARC_LEN  = 5'(MIN_ARC);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                 r_state;
  logic [15:0]            r_bright, r_dark;
  logic [16*DW-1:0]       r_diff_b, r_diff_d;
  logic [4:0]             r_idx, r_run_b, r_run_d;
  logic                   r_hit_b, r_hit_d;
  logic [SCORE_WIDTH-1:0] r_sum_b, r_sum_d, r_score;
  logic                   r_corner, r_out_valid, r_in_ready;

  function automatic logic [4:0] sat16_inc(input logic [4:0] run);
    return (run >= 5'd16) ? 5'd16 : run + 5'd1;
  endfunction

  function automatic logic [SCORE_WIDTH-1:0] pick_score(input logic hb, input logic hd,
                                                        input logic [SCORE_WIDTH-1:0] sb,
                                                        input logic [SCORE_WIDTH-1:0] sd);
    if (hb && hd) return (sb >= sd) ? sb : sd;
    if (hb)       return sb;
    if (hd)       return sd;
    return '0;
  endfunction

  logic [3:0]             w_pos;
  logic                   w_in_ring, w_bit_b, w_bit_d, w_hit_b, w_hit_d, w_last;
  logic [4:0]             w_run_b, w_run_d;
  logic [SCORE_WIDTH-1:0] w_sum_b, w_sum_d;

  always_comb begin
    w_pos     = r_idx[3:0];
    // Positions 16 and up revisit the ring start only to close wrapping arcs.
    w_in_ring = ~r_idx[4];
    w_bit_b   = r_bright[w_pos];
    w_bit_d   = r_dark[w_pos];
    w_run_b   = w_bit_b ? sat16_inc(r_run_b) : 5'd0;
    w_run_d   = w_bit_d ? sat16_inc(r_run_d) : 5'd0;
    w_hit_b   = r_hit_b | (w_bit_b & (w_run_b >= ARC_LEN));
    w_hit_d   = r_hit_d | (w_bit_d & (w_run_d >= ARC_LEN));
    w_sum_b   = w_in_ring ? r_sum_b + SCORE_WIDTH'(r_diff_b[w_pos*DW +: DW]) : r_sum_b;
    w_sum_d   = w_in_ring ? r_sum_d + SCORE_WIDTH'(r_diff_d[w_pos*DW +: DW]) : r_sum_d;
`ifdef FAST_ARC_EARLY_EXIT_EN
    w_last    = (r_idx == LAST_IDX) | ((r_idx == 5'd15) & (w_hit_b | w_hit_d));
`else
    w_last    = (r_idx == LAST_IDX);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bright    <= '0;
      r_dark      <= '0;
      r_diff_b    <= '0;
      r_diff_d    <= '0;
      r_idx       <= '0;
      r_run_b     <= '0;
      r_run_d     <= '0;
      r_hit_b     <= 1'b0;
      r_hit_d     <= 1'b0;
      r_sum_b     <= '0;
      r_sum_d     <= '0;
      r_score     <= '0;
      r_corner    <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (ce) begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_bright   <= bright;
            r_dark     <= dark;
            r_diff_b   <= diff_b;
            r_diff_d   <= diff_d;
            r_idx      <= '0;
            r_run_b    <= '0;
            r_run_d    <= '0;
            r_hit_b    <= 1'b0;
            r_hit_d    <= 1'b0;
            r_sum_b    <= '0;
            r_sum_d    <= '0;
            r_in_ready <= 1'b0;
            r_state    <= SCAN;
          end
        end
        SCAN: begin
          r_idx   <= r_idx + 5'd1;
          r_run_b <= w_run_b;
          r_run_d <= w_run_d;
          r_hit_b <= w_hit_b;
          r_hit_d <= w_hit_d;
          r_sum_b <= w_sum_b;
          r_sum_d <= w_sum_d;
          if (w_last) begin
            r_corner    <= w_hit_b | w_hit_d;
            r_score     <= pick_score(w_hit_b, w_hit_d, w_sum_b, w_sum_d);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign corner    = r_corner;
  assign score     = r_score;

endmodule

// File: tb/tb_fast_arc_scorer.sv
// Self-checking bench for fast_arc_scorer: directed ring patterns plus randomized candidates
// compared against a circular-arc reference model.
`timescale 1ns/1ps
module tb_fast_arc_scorer;
  localparam int PW       = 8;
  localparam int DW       = PW + 2;
  localparam int SW       = PW + 4;
  localparam int MIN_ARC  = 9;
  localparam int SCAN_LEN = 16 + MIN_ARC - 1;

  logic clk = 1'b0, rst_n = 1'b0, ce = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, corner;
  logic [15:0] bright = '0, dark = '0;
  logic [16*DW-1:0] diff_b = '0, diff_d = '0;
  logic [SW-1:0] score;
  int n_cmp = 0, n_fail = 0, cyc = 0;

  fast_arc_scorer #(.PIXEL_WIDTH(PW), .MIN_ARC(MIN_ARC), .SCORE_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .bright(bright), .dark(dark), .diff_b(diff_b), .diff_d(diff_d),
    .out_valid(out_valid), .out_ready(out_ready), .corner(corner), .score(score));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Longest circular run of set bits, capped at the ring size.
  function automatic int circ_run(input logic [15:0] m);
    int best, len;
    best = 0;
    if (m == 16'hFFFF) return 16;
    for (int s = 0; s < 16; s++) begin
      len = 0;
      while (len < 16 && m[(s + len) % 16]) len++;
      if (len > best) best = len;
    end
    return best;
  endfunction

  function automatic int lin_run(input logic [15:0] m);
    int best, len;
    best = 0; len = 0;
    for (int i = 0; i < 16; i++) begin
      len = m[i] ? len + 1 : 0;
      if (len > best) best = len;
    end
    return best;
  endfunction

  function automatic int lane_sum(input logic [16*DW-1:0] v);
    int s;
    s = 0;
    for (int i = 0; i < 16; i++) s += int'(v[i*DW +: DW]);
    return s;
  endfunction

  task automatic model(input logic [15:0] b, input logic [15:0] d,
                       input logic [16*DW-1:0] db, input logic [16*DW-1:0] dd,
                       output logic c, output int sc, output int lat);
    logic hb, hd;
    int sb, sd;
    hb = circ_run(b) >= MIN_ARC;
    hd = circ_run(d) >= MIN_ARC;
    sb = lane_sum(db);
    sd = lane_sum(dd);
    c  = hb | hd;
    if (hb && hd) sc = (sb > sd) ? sb : sd;
    else if (hb)  sc = sb;
    else if (hd)  sc = sd;
    else          sc = 0;
`ifdef FAST_ARC_EARLY_EXIT_EN
    lat = (lin_run(b) >= MIN_ARC || lin_run(d) >= MIN_ARC) ? 16 : SCAN_LEN;
`else
    lat = (lin_run(b) >= 0) ? SCAN_LEN : SCAN_LEN;
`endif
  endtask

  function automatic logic [16*DW-1:0] lanes_for(input logic [15:0] m, input int val, input bit rnd);
    logic [16*DW-1:0] v;
    v = '0;
    for (int i = 0; i < 16; i++)
      if (m[i]) v[i*DW +: DW] = rnd ? DW'($urandom_range(255, 0)) : DW'(val);
    return v;
  endfunction

  function automatic logic [15:0] rand_arc();
    logic [31:0] t, r;
    int len, rot;
    len = $urandom_range(16, 0);
    rot = $urandom_range(15, 0);
    t = (len == 16) ? 32'hFFFF : ((32'h1 << len) - 32'h1);
    r = (t << rot) | (t >> (16 - rot));
    if ($urandom_range(3, 0) == 0) r = r ^ ($urandom & $urandom & 32'hFFFF);
    return r[15:0];
  endfunction

  task automatic gen(output logic [15:0] b, output logic [15:0] d,
                     output logic [16*DW-1:0] db, output logic [16*DW-1:0] dd);
    b = rand_arc();
    d = rand_arc();
    if ($urandom_range(1, 0) == 1) d = d & ~b;
    db = lanes_for(b, 0, 1'b1);
    dd = lanes_for(d, 0, 1'b1);
  endtask

  task automatic accept(input logic [15:0] b, input logic [15:0] d,
                        input logic [16*DW-1:0] db, input logic [16*DW-1:0] dd,
                        output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    bright = b; dark = d; diff_b = db; diff_d = dd; in_valid = 1'b1;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int ce_at, output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (lat == ce_at) ce = 1'b0;
      if (lat == ce_at + 3) ce = 1'b1;
      @(negedge clk);
      lat++;
    end
    ce = 1'b1;
  endtask

  task automatic handshake(input int delay);
    repeat (delay) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (corner !== 1'b0) begin n_fail++; $display("FAIL reset_corner: got %b expected 0", corner); end
    n_cmp++; if (score !== '0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", score); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [15:0] b, d;
    logic [16*DW-1:0] db, dd;
    logic ec, mc;
    int es, ms, ml, lat, acc;
    for (int k = 0; k < 4; k++) begin
      d = '0; dd = '0;
      case (k)
        0: begin b = 16'h01FF; db = lanes_for(b, 5, 1'b0); ec = 1'b1; es = 45; end
        1: begin b = 16'hF01F; db = lanes_for(b, 3, 1'b0); ec = 1'b1; es = 27; end
        2: begin b = 16'h00FF; db = lanes_for(b, 7, 1'b0); ec = 1'b0; es = 0; end
        default: begin b = 16'h0000; db = '0; d = 16'hFFFF; dd = lanes_for(d, 10, 1'b0); ec = 1'b1; es = 160; end
      endcase
      model(b, d, db, dd, mc, ms, ml);
      accept(b, d, db, dd, acc);
      wait_out(-1, lat);
      n_cmp++; if (corner !== ec) begin n_fail++; $display("FAIL directed%0d_corner: got %b expected %b", k, corner, ec); end
      n_cmp++; if (score !== SW'(es)) begin n_fail++; $display("FAIL directed%0d_score: got %0d expected %0d", k, score, es); end
      n_cmp++; if (lat !== ml) begin n_fail++; $display("FAIL directed%0d_latency: got %0d expected %0d", k, lat, ml); end
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL directed%0d_in_ready_done: got %b expected 0", k, in_ready); end
      handshake(0);
    end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] b, d, b2, d2;
    logic [16*DW-1:0] db, dd, db2, dd2;
    logic mc;
    int ms, ml, lat, acc;
    b = 16'h0FF8; d = 16'h0000; db = lanes_for(b, 0, 1'b1); dd = '0;
    b2 = 16'hFFFF; d2 = 16'h0000; db2 = lanes_for(b2, 200, 1'b0); dd2 = '0;
    model(b, d, db, dd, mc, ms, ml);
    accept(b, d, db, dd, acc);
    bright = b2; dark = d2; diff_b = db2; diff_d = dd2; in_valid = 1'b1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL busy_in_ready: got %b expected 0", in_ready); end
    wait_out(-1, lat);
    n_cmp++; if (corner !== mc) begin n_fail++; $display("FAIL busy_corner: got %b expected %b", corner, mc); end
    n_cmp++; if (score !== SW'(ms)) begin n_fail++; $display("FAIL busy_score: got %0d expected %0d", score, ms); end
    in_valid = 1'b0;
    handshake(0);
  endtask

  task automatic test_backpressure();
    logic [15:0] b, d;
    logic [16*DW-1:0] db, dd;
    logic mc;
    int ms, ml, lat, acc;
    gen(b, d, db, dd);
    b = b | 16'h03FE;
    db = lanes_for(b, 0, 1'b1);
    model(b, d, db, dd, mc, ms, ml);
    accept(b, d, db, dd, acc);
    wait_out(-1, lat);
    n_cmp++; if (corner !== mc) begin n_fail++; $display("FAIL bp_corner: got %b expected %b", corner, mc); end
    n_cmp++; if (score !== SW'(ms)) begin n_fail++; $display("FAIL bp_score: got %0d expected %0d", score, ms); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid%0d: got %b expected 1", i, out_valid); end
      n_cmp++; if (score !== SW'(ms) || corner !== mc) begin n_fail++; $display("FAIL bp_hold_data%0d: got %b/%0d expected %b/%0d", i, corner, score, mc, ms); end
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_in_ready%0d: got %b expected 0", i, in_ready); end
    end
    handshake(0);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] b, d, b2, d2;
    logic [16*DW-1:0] db, dd, db2, dd2;
    logic mc, mc2;
    int ms, ml, ms2, ml2, lat, t1, t2;
    gen(b, d, db, dd);
    gen(b2, d2, db2, dd2);
    model(b, d, db, dd, mc, ms, ml);
    model(b2, d2, db2, dd2, mc2, ms2, ml2);
    out_ready = 1'b1;
    accept(b, d, db, dd, t1);
    wait_out(-1, lat);
    n_cmp++; if (score !== SW'(ms) || corner !== mc) begin n_fail++; $display("FAIL b2b_first: got %b/%0d expected %b/%0d", corner, score, mc, ms); end
    accept(b2, d2, db2, dd2, t2);
    n_cmp++; if (t2 - t1 !== ml + 2) begin n_fail++; $display("FAIL b2b_interval: got %0d expected %0d", t2 - t1, ml + 2); end
    wait_out(-1, lat);
    n_cmp++; if (score !== SW'(ms2) || corner !== mc2) begin n_fail++; $display("FAIL b2b_second: got %b/%0d expected %b/%0d", corner, score, mc2, ms2); end
    n_cmp++; if (lat !== ml2) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", lat, ml2); end
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_random();
    logic [15:0] b, d;
    logic [16*DW-1:0] db, dd;
    logic mc;
    int ms, ml, lat, acc;
    for (int n = 0; n < 40; n++) begin
      gen(b, d, db, dd);
      model(b, d, db, dd, mc, ms, ml);
      accept(b, d, db, dd, acc);
      wait_out(-1, lat);
      n_cmp++; if (corner !== mc) begin n_fail++; $display("FAIL rand%0d_corner: b=%h d=%h got %b expected %b", n, b, d, corner, mc); end
      n_cmp++; if (score !== SW'(ms)) begin n_fail++; $display("FAIL rand%0d_score: b=%h d=%h got %0d expected %0d", n, b, d, score, ms); end
      n_cmp++; if (lat !== ml) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", n, lat, ml); end
      handshake($urandom_range(3, 0));
    end
  endtask

  task automatic test_ce();
    logic [15:0] b;
    logic [16*DW-1:0] db;
    logic mc;
    int ms, ml, lat, acc;
    b = 16'h3FE0;
    db = lanes_for(b, 0, 1'b1);
    model(b, 16'h0, db, '0, mc, ms, ml);
    accept(b, 16'h0, db, '0, acc);
    wait_out(5, lat);
    n_cmp++; if (lat !== ml + 3) begin n_fail++; $display("FAIL ce_latency: got %0d expected %0d", lat, ml + 3); end
    n_cmp++; if (corner !== mc || score !== SW'(ms)) begin n_fail++; $display("FAIL ce_result: got %b/%0d expected %b/%0d", corner, score, mc, ms); end
    ce = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ce_done_hold%0d: got %b expected 1", i, out_valid); end
    end
    ce = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ce_done_release: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [16*DW-1:0] db;
    int lat, acc;
    db = lanes_for(16'h01FF, 9, 1'b0);
    accept(16'h01FF, 16'h0, db, '0, acc);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_scan_valid: got %b expected 0", out_valid); end
    n_cmp++; if (score !== '0) begin n_fail++; $display("FAIL rst_scan_score: got %0d expected 0", score); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_scan_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (SCAN_LEN + 4) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_scan_discard: got %b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_scan_idle: got %b expected 1", in_ready); end
    accept(16'h01FF, 16'h0, db, '0, acc);
    wait_out(-1, lat);
    n_cmp++; if (score !== SW'(81) || corner !== 1'b1) begin n_fail++; $display("FAIL rst_done_pre: got %b/%0d expected 1/81", corner, score); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || corner !== 1'b0 || score !== '0) begin n_fail++; $display("FAIL rst_done_clear: got %b/%b/%0d expected 0/0/0", out_valid, corner, score); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_done_in_ready: got %b expected 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_ce();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
